// File: rtl/n_bit_comparator_pkg.sv
// n_bit_comparator_pkg: shared width default, compare result type and one-hot mapping
package n_bit_comparator_pkg;
    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {LT, EQ, GT} cmp_result_t;

    function automatic logic [2:0] to_onehot(cmp_result_t r);
        return {r == LT, r == EQ, r == GT};
    endfunction
endpackage

// File: rtl/n_bit_comparator_cmp_core.sv
// cmp_core: combinational recursive magnitude compare; signed mode flips the sign bits so a plain unsigned tree applies
module cmp_core
    import n_bit_comparator_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter bit SIGNED = 1'b0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output cmp_result_t      result
);
    localparam logic [WIDTH-1:0] SIGN_MASK = SIGNED ? WIDTH'(1) << (WIDTH - 1) : '0;

    logic [WIDTH-1:0] ua;
    logic [WIDTH-1:0] ub;

    assign ua = a ^ SIGN_MASK;
    assign ub = b ^ SIGN_MASK;

    if (WIDTH == 1) begin : g_leaf
        assign result = (ua == ub) ? EQ : (ua[0] ? GT : LT);
    end else begin : g_split
        localparam int LO = WIDTH / 2;
        localparam int HI = WIDTH - LO;
        cmp_result_t r_hi;
        cmp_result_t r_lo;
        cmp_core #(.WIDTH(HI), .SIGNED(1'b0)) u_hi (
            .a      (ua[WIDTH-1:LO]),
            .b      (ub[WIDTH-1:LO]),
            .result (r_hi)
        );
        cmp_core #(.WIDTH(LO), .SIGNED(1'b0)) u_lo (
            .a      (ua[LO-1:0]),
            .b      (ub[LO-1:0]),
            .result (r_lo)
        );
        assign result = (r_hi == EQ) ? r_lo : r_hi;
    end
endmodule

// File: rtl/n_bit_comparator.sv
// n_bit_comparator: registered three-way compare with one-cycle latency and valid qualifier
module n_bit_comparator
    import n_bit_comparator_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic             lesser,
    output logic             equal,
    output logic             greater
);
    cmp_result_t result;

    cmp_core #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_core (
        .a      (a),
        .b      (b),
        .result (result)
    );

    // capture flags on valid input; flags hold when idle, reset wins over capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            {lesser, equal, greater} <= 3'b000;
        end else begin
            out_valid <= in_valid;
            if (in_valid) {lesser, equal, greater} <= to_onehot(result);
        end
    end

`ifndef SYNTHESIS
    a_onehot: assert property (@(posedge clk) out_valid |-> $onehot({lesser, equal, greater}));
    a_latency: assert property (@(posedge clk) $past(rst_n) |-> out_valid == $past(in_valid));
`endif
endmodule

// File: tb/tb_n_bit_comparator.sv
// tb_n_bit_comparator: directed and model-checked tests across widths and signedness
module tb_n_bit_comparator;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [32:0] a_w = '0;
    logic [32:0] b_w = '0;
    logic [5:0]  ov;
    logic [5:0][2:0] fl;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    n_bit_comparator #(.WIDTH(8), .SIGNED(1'b0)) u_u8 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a_w[7:0]), .b(b_w[7:0]), .out_valid(ov[0]), .lesser(fl[0][2]), .equal(fl[0][1]), .greater(fl[0][0]));
    n_bit_comparator #(.WIDTH(8), .SIGNED(1'b1)) u_s8 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a_w[7:0]), .b(b_w[7:0]), .out_valid(ov[1]), .lesser(fl[1][2]), .equal(fl[1][1]), .greater(fl[1][0]));
    n_bit_comparator #(.WIDTH(1), .SIGNED(1'b0)) u_u1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a_w[0:0]), .b(b_w[0:0]), .out_valid(ov[2]), .lesser(fl[2][2]), .equal(fl[2][1]), .greater(fl[2][0]));
    n_bit_comparator #(.WIDTH(1), .SIGNED(1'b1)) u_s1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a_w[0:0]), .b(b_w[0:0]), .out_valid(ov[3]), .lesser(fl[3][2]), .equal(fl[3][1]), .greater(fl[3][0]));
    n_bit_comparator #(.WIDTH(33), .SIGNED(1'b0)) u_u33 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a_w), .b(b_w), .out_valid(ov[4]), .lesser(fl[4][2]), .equal(fl[4][1]), .greater(fl[4][0]));
    n_bit_comparator #(.WIDTH(33), .SIGNED(1'b1)) u_s33 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a_w), .b(b_w), .out_valid(ov[5]), .lesser(fl[5][2]), .equal(fl[5][1]), .greater(fl[5][0]));

    localparam int  WID [6] = '{8, 8, 1, 1, 33, 33};
    localparam bit  SGN [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    // reference: widen to 64-bit signed integers and compare arithmetically
    function automatic logic [2:0] ref_cmp(int w, bit sg, logic [32:0] x, logic [32:0] y);
        logic [63:0] mask;
        longint sx;
        longint sy;
        mask = (64'd1 << w) - 64'd1;
        sx = longint'({31'b0, x} & mask);
        sy = longint'({31'b0, y} & mask);
        if (sg && x[w-1]) sx = sx - (longint'(1) << w);
        if (sg && y[w-1]) sy = sy - (longint'(1) << w);
        return (sx < sy) ? 3'b100 : (sx == sy) ? 3'b010 : 3'b001;
    endfunction

    task automatic step(input logic v, input logic [32:0] x, input logic [32:0] y);
        in_valid = v;
        a_w = x;
        b_w = y;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 33'd5, 33'd9);
            checks++;
            if ({ov[0], fl[0]} !== 4'b0000) begin
                failures++;
                $display("FAIL reset cyc=%0d got=%b exp=0000", i, {ov[0], fl[0]});
            end
        end
        rst_n = 1'b1;
        step(1'b1, 33'd5, 33'd9);
        checks++;
        if ({ov[0], fl[0]} !== 4'b1100) begin
            failures++;
            $display("FAIL first_after_reset got=%b exp=1100", {ov[0], fl[0]});
        end
    endtask

    task automatic test_unsigned();
        logic [7:0] va [11] = '{8'd24, 8'd50, 8'd52, 8'd24, 8'd80, 8'd50, 8'd0, 8'd255, 8'd255, 8'd128, 8'd0};
        logic [7:0] vb [11] = '{8'd56, 8'd24, 8'd54, 8'd24, 8'd51, 8'd51, 8'd255, 8'd255, 8'd0, 8'd127, 8'd1};
        logic [2:0] ve [11] = '{3'b100, 3'b001, 3'b100, 3'b010, 3'b001, 3'b100, 3'b100, 3'b010, 3'b001, 3'b001, 3'b100};
        for (int i = 0; i < 11; i++) begin
            step(1'b1, {25'b0, va[i]}, {25'b0, vb[i]});
            checks++;
            if ({ov[0], fl[0]} !== {1'b1, ve[i]}) begin
                failures++;
                $display("FAIL unsigned %0d vs %0d got=%b exp=%b", va[i], vb[i], {ov[0], fl[0]}, {1'b1, ve[i]});
            end
        end
    endtask

    task automatic test_signed();
        logic [7:0] va [4] = '{8'h80, 8'hFF, 8'hFE, 8'h05};
        logic [7:0] vb [4] = '{8'h7F, 8'h00, 8'hFF, 8'h05};
        logic [2:0] vs [4] = '{3'b100, 3'b100, 3'b100, 3'b010};
        logic [2:0] vu [4] = '{3'b001, 3'b001, 3'b100, 3'b010};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, {25'b0, va[i]}, {25'b0, vb[i]});
            checks++;
            if ({ov[1], fl[1]} !== {1'b1, vs[i]}) begin
                failures++;
                $display("FAIL signed %h vs %h got=%b exp=%b", va[i], vb[i], {ov[1], fl[1]}, {1'b1, vs[i]});
            end
            checks++;
            if (fl[0] !== vu[i]) begin
                failures++;
                $display("FAIL signed_as_unsigned %h vs %h got=%b exp=%b", va[i], vb[i], fl[0], vu[i]);
            end
        end
    endtask

    task automatic test_valid_gating();
        step(1'b1, 33'd10, 33'd20);
        checks++;
        if ({ov[0], fl[0]} !== 4'b1100) begin
            failures++;
            $display("FAIL gate_first got=%b exp=1100", {ov[0], fl[0]});
        end
        step(1'b0, 33'd99, 33'd1);
        checks++;
        if ({ov[0], fl[0]} !== 4'b0100) begin
            failures++;
            $display("FAIL gate_idle_hold got=%b exp=0100", {ov[0], fl[0]});
        end
        step(1'b1, 33'd7, 33'd7);
        checks++;
        if ({ov[0], fl[0]} !== 4'b1010) begin
            failures++;
            $display("FAIL gate_third got=%b exp=1010", {ov[0], fl[0]});
        end
        step(1'b1, 33'd3, 33'd4);
        rst_n = 1'b0;
        step(1'b1, 33'd9, 33'd2);
        checks++;
        if ({ov[0], fl[0]} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_after_capture got=%b exp=0000", {ov[0], fl[0]});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [32:0] x;
        logic [32:0] y;
        logic [2:0]  e;
        for (int n = 0; n < 1000; n++) begin
            x = {1'($urandom_range(0, 1)), 32'($urandom)};
            y = (n % 8 == 0) ? x : {1'($urandom_range(0, 1)), 32'($urandom)};
            if (n % 8 == 1) y[32:8] = x[32:8];
            step(1'b1, x, y);
            for (int k = 0; k < 6; k++) begin
                e = ref_cmp(WID[k], SGN[k], x, y);
                checks++;
                if ({ov[k], fl[k]} !== {1'b1, e}) begin
                    failures++;
                    $display("FAIL random inst=%0d a=%h b=%h got=%b exp=%b", k, x, y, {ov[k], fl[k]}, {1'b1, e});
                end
                checks++;
                if (!$onehot(fl[k])) begin
                    failures++;
                    $display("FAIL onehot inst=%0d got=%b exp=onehot", k, fl[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_valid_gating();
        test_random();
        step(1'b0, '0, '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
